// File: rtl/mux_sel_reg.sv
// mux_sel_reg: registered N-way source selector with a one-entry output register.
// Ports: clk, reset (async, active-high), mode, selector, data_in[CHANNELS*WIDTH],
//        in_valid/in_ready[CHANNELS], data_out, out_valid, out_ready, out_chan.
module mux_sel_reg #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          selector,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          data_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic [WIDTH-1:0]    r_data;
    logic                r_valid;
    logic [SEL_W-1:0]    r_chan;
    logic [SEL_W-1:0]    r_rr_ptr;

    logic                w_load_ok;
    logic [SEL_W-1:0]    w_dir_g;
    logic                w_rr_found;
    logic [SEL_W-1:0]    w_rr_g;
    logic [SEL_W-1:0]    w_gnt;
    logic                w_gnt_vld;
    logic [CHANNELS-1:0] w_ready;
    logic                w_xfer_in;
    logic [WIDTH-1:0]    w_word;
    logic [SEL_W-1:0]    w_ptr_nxt;

    assign w_load_ok = !r_valid || out_ready;

    // Out-of-range selector values fall back to channel 0.
    assign w_dir_g = (32'(selector) < CHANNELS) ? selector : '0;

    // Cyclic priority scan starting at the round-robin pointer.
    always_comb begin
        int idx;
        w_rr_found = 1'b0;
        w_rr_g     = '0;
        idx        = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!w_rr_found && |(in_valid & (CHANNELS'(1) << idx))) begin
                w_rr_found = 1'b1;
                w_rr_g     = SEL_W'(idx);
            end
        end
    end

    assign w_gnt     = mode ? w_rr_g : w_dir_g;
    assign w_gnt_vld = mode ? w_rr_found : 1'b1;

    assign w_ready   = (w_load_ok && w_gnt_vld) ? (CHANNELS'(1) << w_gnt) : '0;
    assign in_ready  = w_ready;
    assign w_xfer_in = |(in_valid & w_ready);

    always_comb begin
        w_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_word = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointer wraps at CHANNELS, not at the selector width.
    assign w_ptr_nxt = (32'(w_gnt) == CHANNELS - 1) ? '0 : w_gnt + SEL_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_chan   <= '0;
            r_rr_ptr <= '0;
        end else if (w_xfer_in) begin
            r_data  <= w_word;
            r_chan  <= w_gnt;
            r_valid <= 1'b1;
            if (mode) begin
                r_rr_ptr <= w_ptr_nxt;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign out_valid = r_valid;
    assign out_chan  = r_chan;

endmodule

// File: tb/tb_mux_sel_reg.sv
// tb_mux_sel_reg: directed-vector bench for mux_sel_reg.
// Default 4x32 instance plus a 5-channel, 3-bit-selector instance.
module tb_mux_sel_reg;

    logic        clk;
    logic        reset;

    logic        mode;
    logic [1:0]  sel;
    logic [127:0] din;
    logic [3:0]  iv;
    logic [3:0]  ir;
    logic [31:0] dout;
    logic        ov;
    logic        ordy;
    logic [1:0]  ochan;

    logic        mode_b;
    logic [2:0]  sel_b;
    logic [39:0] din_b;
    logic [4:0]  iv_b;
    logic [4:0]  ir_b;
    logic [7:0]  dout_b;
    logic        ov_b;
    logic        ordy_b;
    logic [2:0]  ochan_b;

    int n_cmp;
    int n_err;

    mux_sel_reg u_dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .selector  (sel),
        .data_in   (din),
        .in_valid  (iv),
        .in_ready  (ir),
        .data_out  (dout),
        .out_valid (ov),
        .out_ready (ordy),
        .out_chan  (ochan)
    );

    mux_sel_reg #(
        .WIDTH    (8),
        .CHANNELS (5),
        .SEL_W    (3)
    ) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode_b),
        .selector  (sel_b),
        .data_in   (din_b),
        .in_valid  (iv_b),
        .in_ready  (ir_b),
        .data_out  (dout_b),
        .out_valid (ov_b),
        .out_ready (ordy_b),
        .out_chan  (ochan_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mode = 1'b0;
        sel  = 2'd1;
        din  = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        iv   = 4'b0010;
        ordy = 1'b0;
        step();
        n_cmp++;
        if (dout !== 32'hDEADBEEF || ov !== 1'b1) begin
            n_err++;
            $display("FAIL reset_preload: got %h/%b want deadbeef/1", dout, ov);
        end
        iv = 4'b0000;
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 0", dout);
        end
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b want 0", ov);
        end
        n_cmp++;
        if (ochan !== 2'd0) begin
            n_err++;
            $display("FAIL reset_chan: got %0d want 0", ochan);
        end
        #1;
        reset = 1'b0;
        iv = 4'b0010;
        #1;
        n_cmp++;
        if (ir !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0010", ir);
        end
        iv = 4'b0000;
        step();
    endtask

    task automatic test_direct();
        mode = 1'b0;
        sel  = 2'd2;
        din  = {32'h33, 32'h22, 32'h11, 32'h00};
        iv   = 4'b0100;
        ordy = 1'b1;
        #1;
        n_cmp++;
        if (ir !== 4'b0100) begin
            n_err++;
            $display("FAIL direct_ready: got %b want 0100", ir);
        end
        step();
        n_cmp++;
        if (dout !== 32'h22 || ochan !== 2'd2 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL direct_load: got %h/%0d/%b want 22/2/1", dout, ochan, ov);
        end
        iv = 4'b0000;
        step();
        n_cmp++;
        if (ov !== 1'b0 || dout !== 32'h22) begin
            n_err++;
            $display("FAIL direct_drain: got %h/%b want 22/0", dout, ov);
        end
    endtask

    task automatic test_direct_oob();
        mode_b = 1'b0;
        ordy_b = 1'b1;
        din_b  = {8'hE4, 8'hE3, 8'hE2, 8'hE1, 8'hA0};
        iv_b   = 5'b11111;
        sel_b  = 3'b111;
        #1;
        n_cmp++;
        if (ir_b !== 5'b00001) begin
            n_err++;
            $display("FAIL oob_ready: got %b want 00001", ir_b);
        end
        step();
        n_cmp++;
        if (dout_b !== 8'hA0 || ochan_b !== 3'd0) begin
            n_err++;
            $display("FAIL oob7_load: got %h/%0d want a0/0", dout_b, ochan_b);
        end
        sel_b = 3'd4;
        step();
        n_cmp++;
        if (dout_b !== 8'hE4 || ochan_b !== 3'd4) begin
            n_err++;
            $display("FAIL sel4_load: got %h/%0d want e4/4", dout_b, ochan_b);
        end
        sel_b = 3'd5;
        step();
        n_cmp++;
        if (dout_b !== 8'hA0 || ochan_b !== 3'd0) begin
            n_err++;
            $display("FAIL oob5_load: got %h/%0d want a0/0", dout_b, ochan_b);
        end
        iv_b = 5'b00000;
        step();
    endtask

    task automatic test_backpressure();
        mode = 1'b0;
        sel  = 2'd1;
        din  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h10000000};
        iv   = 4'hF;
        ordy = 1'b0;
        step();
        n_cmp++;
        if (dout !== 32'h11111111 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL bp_load: got %h/%b want 11111111/1", dout, ov);
        end
        din[63:32] = 32'h11112222;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (ir !== 4'b0000) begin
                n_err++;
                $display("FAIL bp_ready c%0d: got %b want 0000", c, ir);
            end
            step();
            n_cmp++;
            if (dout !== 32'h11111111 || ov !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold c%0d: got %h/%b want 11111111/1", c, dout, ov);
            end
        end
        ordy = 1'b1;
        #1;
        n_cmp++;
        if (ir !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_release_ready: got %b want 0010", ir);
        end
        step();
        n_cmp++;
        if (dout !== 32'h11112222 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL bp_no_bubble: got %h/%b want 11112222/1", dout, ov);
        end
        iv = 4'h0;
        step();
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL bp_drain: got %b want 0", ov);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_all [5];
        logic [1:0] exp_13 [4];
        exp_all = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_13  = '{2'd1, 2'd3, 2'd1, 2'd3};
        mode = 1'b1;
        din  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        iv   = 4'hF;
        ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (ochan !== exp_all[i] || dout !== 32'hC0 + 32'(exp_all[i])) begin
                n_err++;
                $display("FAIL rr_all i%0d: got %0d/%h want %0d", i, ochan, dout, exp_all[i]);
            end
        end
        iv = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (ochan !== exp_13[i] || ov !== 1'b1) begin
                n_err++;
                $display("FAIL rr_13 i%0d: got %0d/%b want %0d/1", i, ochan, ov, exp_13[i]);
            end
        end
    endtask

    task automatic test_wrap_hold();
        mode = 1'b0;
        sel  = 2'd2;
        iv   = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (ochan !== 2'd2 || dout !== 32'hC2) begin
                n_err++;
                $display("FAIL wrap_direct i%0d: got %0d/%h want 2/c2", i, ochan, dout);
            end
        end
        mode = 1'b1;
        #1;
        n_cmp++;
        if (ir !== 4'b0001) begin
            n_err++;
            $display("FAIL wrap_ready: got %b want 0001", ir);
        end
        step();
        n_cmp++;
        if (ochan !== 2'd0 || dout !== 32'hC0) begin
            n_err++;
            $display("FAIL wrap_first: got %0d/%h want 0/c0", ochan, dout);
        end
    endtask

    task automatic test_mode_change();
        iv = 4'h0;
        step();
        mode = 1'b0;
        sel  = 2'd1;
        iv   = 4'hF;
        ordy = 1'b0;
        step();
        n_cmp++;
        if (ochan !== 2'd1 || dout !== 32'hC1 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL mc_load: got %0d/%h/%b want 1/c1/1", ochan, dout, ov);
        end
        mode = 1'b1;
        step();
        n_cmp++;
        if (ochan !== 2'd1 || dout !== 32'hC1 || ir !== 4'b0000) begin
            n_err++;
            $display("FAIL mc_hold_rr: got %0d/%h/%b want 1/c1/0000", ochan, dout, ir);
        end
        mode = 1'b0;
        sel  = 2'd3;
        step();
        n_cmp++;
        if (ochan !== 2'd1 || dout !== 32'hC1 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL mc_hold_dir: got %0d/%h/%b want 1/c1/1", ochan, dout, ov);
        end
        ordy = 1'b1;
        step();
        n_cmp++;
        if (ochan !== 2'd3 || dout !== 32'hC3 || ov !== 1'b1) begin
            n_err++;
            $display("FAIL mc_next: got %0d/%h/%b want 3/c3/1", ochan, dout, ov);
        end
        iv = 4'h0;
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        reset  = 1'b1;
        mode   = 1'b0;
        sel    = '0;
        din    = '0;
        iv     = '0;
        ordy   = 1'b0;
        mode_b = 1'b0;
        sel_b  = '0;
        din_b  = '0;
        iv_b   = '0;
        ordy_b = 1'b1;
        #12;
        reset = 1'b0;
        step();
        test_reset();
        test_direct();
        test_direct_oob();
        test_backpressure();
        test_round_robin();
        test_wrap_hold();
        test_mode_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
